iob_eth_frame_tx: RTL

IOB_ETH_FRAME_TX -- requirements
Module: iob_eth_frame_tx

---
 rtl/iob_eth_frame_tx_pkg.sv | 24 ++
 rtl/iob_eth_crc32.sv | 21 ++
 rtl/iob_eth_frame_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/iob_eth_frame_tx_pkg.sv
// iob_eth_frame_tx_pkg: state encodings and wire constants shared by the MII
// frame transmitter and its CRC helper. Defining ETH_TX_CRC_EN adds the CRC
// state to the encoding.
package iob_eth_frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        DATA     = 3'd3,
`ifdef ETH_TX_CRC_EN
        CRC      = 3'd4,
`endif
        IFG      = 3'd5
    } tx_state_e;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    localparam logic [3:0] PRE_NIB  = 4'h5;
    localparam logic [3:0] SFD_NIB0 = 4'h5;
    localparam logic [3:0] SFD_NIB1 = 4'hD;

endpackage

// File: rtl/iob_eth_crc32.sv
// iob_eth_crc32: one-nibble step of the reflected IEEE 802.3 CRC-32.
// Purely combinational; the caller owns the state register.
module iob_eth_crc32
    import iob_eth_frame_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nib,
    output logic [31:0] crc_out
);

    // Fold the nibble in LSB first, matching low-nibble-first transmit order
    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {28'd0, nib};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/iob_eth_frame_tx.sv
// iob_eth_frame_tx: streams a frame from a synchronous-read buffer onto MII
// as preamble, SFD, payload (low nibble first) and an optional FCS, followed
// by the inter-frame gap. Define ETH_TX_CRC_EN to append the FCS.
//
// state    | meaning
// IDLE     | ready, waiting for send with nonzero len
// PREAMBLE | emitting 2*PREAMBLE_BYTES nibbles of 0x5
// SFD      | emitting 0x5 then 0xD
// DATA     | emitting payload nibbles, byte 0..len-1
// CRC      | emitting the 8 FCS nibbles (ETH_TX_CRC_EN only)
// IFG      | tx_en low for IFG_NIBBLES cycles before ready
module iob_eth_frame_tx
    import iob_eth_frame_tx_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_NIBBLES    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [ADDR_W-1:0] len,
    output logic              ready,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data,
    output logic              tx_en,
    output logic [3:0]        tx_data
);

    localparam logic [7:0]        PRE_LAST = 8'(2 * PREAMBLE_BYTES - 1);
    localparam logic [7:0]        IFG_LAST = 8'(IFG_NIBBLES - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    tx_state_e         state;
    logic [7:0]        tmr;
    logic [ADDR_W-1:0] byte_cnt;
    logic [3:0]        hi_nib;
    logic              hi;
    logic              accept;
    logic [3:0]        next_nib;

    assign accept = (state == IDLE) && send && (len != '0);

    // Nibble that goes on the wire whenever the payload advances
    always_comb begin
        next_nib = data[3:0];
        if (state == DATA && !hi) next_nib = hi_nib;
    end

`ifdef ETH_TX_CRC_EN
    logic [31:0] crc_r;
    logic [31:0] crc_next;
    logic        load_nib;

    assign load_nib = (state == SFD && tmr == 8'd0) ||
                      (state == DATA && !(hi && byte_cnt == '0));

    iob_eth_crc32 u_crc (
        .crc_in  (crc_r),
        .nib     (next_nib),
        .crc_out (crc_next)
    );

    // FCS accumulator: seeded on accept, folded per payload nibble, then shifted out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_r <= CRC_INIT;
        end else if (accept) begin
            crc_r <= CRC_INIT;
        end else if (load_nib) begin
            crc_r <= crc_next;
        end else if (state == DATA || state == CRC) begin
            crc_r <= {4'hF, crc_r[31:4]};
        end
    end
`endif

    // Frame sequencer; outputs are registered and describe the current nibble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            tx_en    <= 1'b0;
            tx_data  <= 4'h0;
            addr     <= '0;
            tmr      <= 8'd0;
            byte_cnt <= '0;
            hi_nib   <= 4'h0;
            hi       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= PREAMBLE;
                        ready    <= 1'b0;
                        tx_en    <= 1'b1;
                        tx_data  <= PRE_NIB;
                        tmr      <= PRE_LAST;
                        byte_cnt <= len - ONE;
                    end
                end
                PREAMBLE: begin
                    if (tmr == 8'd0) begin
                        state   <= SFD;
                        tx_data <= SFD_NIB0;
                        tmr     <= 8'd1;
                    end else begin
                        tx_data <= PRE_NIB;
                        tmr     <= tmr - 8'd1;
                    end
                end
                SFD: begin
                    if (tmr != 8'd0) begin
                        tx_data <= SFD_NIB1;
                        tmr     <= 8'd0;
                    end else begin
                        // byte 0 has been on the read port since IDLE
                        state   <= DATA;
                        tx_data <= next_nib;
                        hi_nib  <= data[7:4];
                        hi      <= 1'b0;
                        addr    <= (byte_cnt != '0) ? ONE : '0;
                    end
                end
                DATA: begin
                    if (!hi) begin
                        tx_data <= next_nib;
                        hi      <= 1'b1;
                    end else if (byte_cnt != '0) begin
                        // addr ran one byte ahead, so data already holds this byte
                        tx_data  <= next_nib;
                        hi_nib   <= data[7:4];
                        hi       <= 1'b0;
                        byte_cnt <= byte_cnt - ONE;
                        if (byte_cnt != ONE) addr <= addr + ONE;
                    end else begin
                        addr <= '0;
`ifdef ETH_TX_CRC_EN
                        state   <= CRC;
                        tx_data <= ~crc_r[3:0];
                        tmr     <= 8'd7;
`else
                        state   <= IFG;
                        tx_en   <= 1'b0;
                        tx_data <= 4'h0;
                        tmr     <= IFG_LAST;
`endif
                    end
                end
`ifdef ETH_TX_CRC_EN
                CRC: begin
                    if (tmr != 8'd0) begin
                        tx_data <= ~crc_r[3:0];
                        tmr     <= tmr - 8'd1;
                    end else begin
                        state   <= IFG;
                        tx_en   <= 1'b0;
                        tx_data <= 4'h0;
                        tmr     <= IFG_LAST;
                    end
                end
`endif
                IFG: begin
                    if (tmr == 8'd0) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready   <= 1'b1;
                    tx_en   <= 1'b0;
                    tx_data <= 4'h0;
                    addr    <= '0;
                end
            endcase
        end
    end

endmodule
